// File: rtl/ram_pkg.sv
// Shared widths and word/address types for the experiment-3 data/instruction RAM.
package ram_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 512;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage : ram_pkg

// File: rtl/ram_array.sv
// Plain storage array: synchronous write, combinational read, no reset.
module ram_array #(
  parameter int unsigned ADDR_W = ram_pkg::ADDR_W,
  parameter int unsigned DATA_W = ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] ad,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[ad] <= wd;
    end
  end

  // Read data is registered by the caller, together with the valid check.
  assign rd_c = mem[ad];

endmodule : ram_array

// File: rtl/ram.sv
// Single-port 512x16 RAM, active-low write enable, write-first registered output.
// Reset invalidates every word rather than clearing the array.
module ram #(
  parameter int unsigned ADDR_W = ram_pkg::ADDR_W,
  parameter int unsigned DATA_W = ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ad,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0]  vld;
  logic [DATA_W-1:0] rd_c;
  logic              wr_c;

  // Writes are suppressed while reset is held.
  assign wr_c = ~WE & rst_n;

  ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (wr_c),
    .ad   (ad),
    .wd   (in),
    .rd_c (rd_c)
  );

  // Valid vector and write-through output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      out <= '0;
    end else if (!WE) begin
      vld[ad] <= 1'b1;
      out     <= in;
    end else begin
      out <= vld[ad] ? rd_c : DATA_W'(0);
    end
  end

endmodule : ram

// File: tb/tb_ram.sv
// Scoreboard bench for ram: stimulus queues expected reads, a monitor pops and compares.
module tb_ram;
  import ram_pkg::*;

  typedef struct {
    string name;
    word_t val;
  } exp_t;

  logic  clk;
  logic  rst_n;
  logic  WE;
  addr_t ad;
  word_t in;
  word_t out;

  exp_t  sb[$];
  int    checks;
  int    errors;

  ram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .WE    (WE),
    .ad    (ad),
    .in    (in),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge and queue what out must show after the next rise.
  task automatic op(input logic we, input addr_t a, input word_t d, input word_t exp,
                    input string name);
    @(negedge clk);
    WE = we;
    ad = a;
    in = d;
    sb.push_back('{name: name, val: exp});
  endtask

  task automatic wr(input addr_t a, input word_t d, input string name);
    op(1'b0, a, d, d, name);
  endtask

  task automatic rd(input addr_t a, input word_t exp, input string name);
    op(1'b1, a, '0, exp, name);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d entries left, required 0", name, sb.size());
    end
  endtask

  // Monitor: out is sampled just after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        compare(e.name, out, e.val);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    WE     = 1'b1;
    ad     = '0;
    in     = '0;
    repeat (3) @(posedge clk);
    #1;
    compare("reset_out", out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    rd(9'd256, 16'h0000, "unwritten_256");
    rd(9'd5,   16'h0000, "unwritten_5");

    wr(9'd0, 16'h000f, "wr0");
    wr(9'd1, 16'h00f0, "wr1");
    rd(9'd0, 16'h000f, "rd0");
    rd(9'd1, 16'h00f0, "rd1");

    wr(9'd7, 16'ha5a5, "write_through");
    rd(9'd7, 16'ha5a5, "rd7");

    wr(9'd511, 16'h1234, "wr511_a");
    wr(9'd511, 16'h5678, "wr511_b");
    rd(9'd511, 16'h5678, "overwrite511");
    rd(9'd0,   16'h000f, "addr0_kept");

    for (int i = 0; i < 4; i++) begin
      wr(9'(100 + i), 16'(16'hc000 + i * 16'h0111), "burst_wr");
    end
    for (int i = 3; i >= 0; i--) begin
      rd(9'(100 + i), 16'(16'hc000 + i * 16'h0111), "burst_rd");
    end

    wr(9'd3, 16'hbeef, "wr3");
    drain("drain_pre_reset");

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    compare("async_reset_out", out, 16'h0000);
    @(negedge clk);
    WE = 1'b0;
    ad = 9'd3;
    in = 16'hdead;
    repeat (2) @(posedge clk);
    #1;
    compare("write_during_reset", out, 16'h0000);
    @(negedge clk);
    WE    = 1'b1;
    ad    = 9'd3;
    rst_n = 1'b1;

    rd(9'd3,   16'h0000, "invalidated3");
    rd(9'd0,   16'h0000, "invalidated0");
    rd(9'd7,   16'h0000, "invalidated7");
    wr(9'd3,   16'h0001, "rewrite3");
    rd(9'd3,   16'h0001, "rd_rewrite3");
    rd(9'd256, 16'h0000, "unwritten_256_b");
    drain("drain_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

endmodule : tb_ram
